// File: rtl/cp0_mmu_sync_pkg.sv
// Shared definitions for the CP0 <-> MMU shadow sync engine: FSM states,
// transfer direction codes and the default slot-to-CP0-register map.
package cp0_mmu_sync_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PUSH  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_PULL  = 3'd3,
    ST_DONE  = 3'd4
  } sync_state_t;

  localparam logic SYNC_DIR_PUSH = 1'b0;
  localparam logic SYNC_DIR_PULL = 1'b1;

  // Slot 0 in the low bits: Index, Random, EntryLo0, EntryLo1, Context, PageMask, Wired, EntryHi
  localparam logic [39:0] SYNC_DEFAULT_REG_MAP = {5'd10, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};

endpackage

// File: rtl/cp0_mmu_sync_next_slot.sv
// Combinational priority encoder: lowest set bit of mask at or above index from.
// none is high when no candidate remains.
module sync_next_slot #(
  parameter int NUM_REGS = 8,
  parameter int K_W      = $clog2(NUM_REGS) + 1
) (
  input  logic [NUM_REGS-1:0] mask,
  input  logic [K_W-1:0]      from,
  output logic [K_W-1:0]      slot,
  output logic                none
);

  // Scan downwards so the lowest qualifying slot is the last one written.
  always_comb begin
    slot = '0;
    none = 1'b1;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i] && (K_W'(i) >= from)) begin
        slot = K_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cp0_mmu_sync.sv
// Moves CP0 register values to/from the MMU shadow copies, one slot per cycle.
// Optional dirty tracking (push only the slots written by MTC0): CP0_MMU_SYNC_DIRTY_EN.
module cp0_mmu_sync
  import cp0_mmu_sync_pkg::*;
#(
  parameter int                        DATA_W   = 32,
  parameter int                        NUM_REGS = 8,
  parameter int                        IDX_W    = 5,
  parameter logic [NUM_REGS*IDX_W-1:0] REG_MAP  = SYNC_DEFAULT_REG_MAP
) (
  input  logic                       clk,
  input  logic                       res_n,
  input  logic                       start,
  input  logic                       dir,
  input  logic                       flush,
  input  logic [NUM_REGS-1:0]        pull_mask,
  output logic                       busy,
  output logic                       done,
  output logic                       cp0_re,
  output logic                       cp0_we,
  output logic [IDX_W-1:0]           cp0_rd,
  output logic [2:0]                 cp0_sel,
  input  logic [DATA_W-1:0]          cp0_rdata,
  output logic [DATA_W-1:0]          cp0_wdata,
  input  logic [NUM_REGS*DATA_W-1:0] mmu_rdata,
  output logic [NUM_REGS*DATA_W-1:0] shadow,
  output logic                       shadow_valid
`ifdef CP0_MMU_SYNC_DIRTY_EN
  ,
  input  logic                       cp0_wr_strobe,
  input  logic [IDX_W-1:0]           cp0_wr_rd
`endif
);

  localparam int K_W = $clog2(NUM_REGS) + 1;

  sync_state_t          state_reg, state_next;
  logic [K_W-1:0]       k_reg, k_next;
  logic [K_W-1:0]       cap_slot_reg, cap_slot_next;
  logic                 cap_valid_reg, cap_valid_next;
  logic [NUM_REGS-1:0]  mask_reg, mask_next;
  logic                 shadow_valid_reg, shadow_valid_next;
  logic [IDX_W-1:0]     rd_hold_reg, map_rd;
  logic [DATA_W-1:0]    wdata_hold_reg, mmu_slot;
  logic                 cur_masked, capture_en, pull_wr;
  logic [NUM_REGS-1:0]  push_mask, enc_mask, cap_hit, pull_hit;
  logic [K_W-1:0]       enc_from, enc_slot;
  logic                 enc_none;
  logic [DATA_W-1:0]    shadow_reg [NUM_REGS];

  always_comb begin
    map_rd     = '0;
    mmu_slot   = '0;
    cur_masked = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (k_reg == K_W'(i)) begin
        map_rd     = REG_MAP[i*IDX_W +: IDX_W];
        mmu_slot   = mmu_rdata[i*DATA_W +: DATA_W];
        cur_masked = mask_reg[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slot
      assign cap_hit[gi]  = capture_en && (cap_slot_reg == K_W'(gi));
      assign pull_hit[gi] = pull_wr && (k_reg == K_W'(gi));
      assign shadow[gi*DATA_W +: DATA_W] = shadow_reg[gi];
    end
  endgenerate

`ifdef CP0_MMU_SYNC_DIRTY_EN
  logic [NUM_REGS-1:0] dirty_reg, dirty_set;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dirty
      assign dirty_set[gi] = flush || (cp0_wr_strobe && (cp0_wr_rd == REG_MAP[gi*IDX_W +: IDX_W]));
    end
  endgenerate

  // A strobe landing on the slot being captured wins, so a racing MTC0 is re-pushed.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) dirty_reg <= '1;
    else        dirty_reg <= (dirty_reg & ~(cap_hit | pull_hit)) | dirty_set;
  end

  assign push_mask = shadow_valid_reg ? dirty_reg : '1;
`else
  assign push_mask = '1;
`endif

  always_comb begin
    enc_mask = mask_reg;
    enc_from = k_reg + K_W'(1);
    if (state_reg == ST_IDLE) begin
      enc_mask = push_mask;
      enc_from = '0;
    end
  end

  sync_next_slot #(.NUM_REGS(NUM_REGS), .K_W(K_W)) u_next_slot (
    .mask (enc_mask),
    .from (enc_from),
    .slot (enc_slot),
    .none (enc_none)
  );

  always_comb begin
    state_next        = state_reg;
    k_next            = k_reg;
    mask_next         = mask_reg;
    cap_slot_next     = cap_slot_reg;
    cap_valid_next    = cap_valid_reg;
    shadow_valid_next = shadow_valid_reg;
    capture_en        = 1'b0;
    pull_wr           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cap_valid_next = 1'b0;
        if (start && !flush) begin
          k_next = '0;
          if (dir == SYNC_DIR_PULL) begin
            mask_next  = pull_mask;
            state_next = ST_PULL;
          end else begin
            mask_next = push_mask;
            if (enc_none) begin
              state_next = ST_DONE;
            end else begin
              k_next     = enc_slot;
              state_next = ST_PUSH;
            end
          end
        end
      end
      ST_PUSH: begin
        // Data for the previously addressed slot arrives while the next read issues.
        capture_en     = cap_valid_reg;
        cap_slot_next  = k_reg;
        cap_valid_next = 1'b1;
        if (enc_none) state_next = ST_DRAIN;
        else          k_next     = enc_slot;
      end
      ST_DRAIN: begin
        capture_en        = cap_valid_reg;
        cap_valid_next    = 1'b0;
        shadow_valid_next = 1'b1;
        state_next        = ST_DONE;
      end
      ST_PULL: begin
        pull_wr = cur_masked;
        if (k_reg == K_W'(NUM_REGS - 1)) state_next = ST_DONE;
        else                             k_next     = k_reg + K_W'(1);
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush && (state_reg != ST_IDLE)) begin
      state_next        = ST_IDLE;
      shadow_valid_next = 1'b0;
      cap_valid_next    = 1'b0;
      capture_en        = 1'b0;
      pull_wr           = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_reg        <= ST_IDLE;
      k_reg            <= '0;
      mask_reg         <= '0;
      cap_slot_reg     <= '0;
      cap_valid_reg    <= 1'b0;
      shadow_valid_reg <= 1'b0;
      rd_hold_reg      <= '0;
      wdata_hold_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      k_reg            <= k_next;
      mask_reg         <= mask_next;
      cap_slot_reg     <= cap_slot_next;
      cap_valid_reg    <= cap_valid_next;
      shadow_valid_reg <= shadow_valid_next;
      rd_hold_reg      <= cp0_rd;
      wdata_hold_reg   <= cp0_wdata;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cap_hit[i])       shadow_reg[i] <= cp0_rdata;
        else if (pull_hit[i]) shadow_reg[i] <= mmu_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign busy         = (state_reg != ST_IDLE);
  assign done         = (state_reg == ST_DONE);
  assign cp0_re       = (state_reg == ST_PUSH);
  assign cp0_we       = (state_reg == ST_PULL) && cur_masked;
  assign cp0_rd       = (cp0_re || cp0_we) ? map_rd : rd_hold_reg;
  assign cp0_wdata    = cp0_we ? mmu_slot : wdata_hold_reg;
  assign cp0_sel      = 3'd0;
  assign shadow_valid = shadow_valid_reg;

endmodule

// File: tb/tb_cp0_mmu_sync.sv
// Randomized self-checking bench for cp0_mmu_sync against a slot-level reference model.
// Builds with or without CP0_MMU_SYNC_DIRTY_EN.
module tb_cp0_mmu_sync;

  logic         clk = 1'b0;
  logic         res_n = 1'b0;
  logic         start = 1'b0, dir = 1'b0, flush = 1'b0;
  logic [7:0]   pull_mask = '0;
  logic         busy, done, cp0_re, cp0_we, shadow_valid;
  logic [4:0]   cp0_rd;
  logic [2:0]   cp0_sel;
  logic [31:0]  cp0_rdata = '0, cp0_wdata;
  logic [255:0] mmu_rdata = '0, shadow;
  logic         core_we = 1'b0;
  logic [4:0]   core_rd = '0;
  logic [31:0]  core_wd = '0;

  logic [31:0]  cp0_mem [32];
  logic [31:0]  cp0_model [32];
  logic [31:0]  sh_model [8];
  logic         sv_model = 1'b0;
  logic [7:0]   dirty_model = 8'hFF;
  int           map_ref [8] = '{0, 1, 2, 3, 4, 5, 6, 10};
  int           vq[$];
  int           tests_run = 0, tests_failed = 0, op_num = 0;

  always #5 clk = ~clk;

  cp0_mmu_sync dut (
    .clk          (clk),
    .res_n        (res_n),
    .start        (start),
    .dir          (dir),
    .flush        (flush),
    .pull_mask    (pull_mask),
    .busy         (busy),
    .done         (done),
    .cp0_re       (cp0_re),
    .cp0_we       (cp0_we),
    .cp0_rd       (cp0_rd),
    .cp0_sel      (cp0_sel),
    .cp0_rdata    (cp0_rdata),
    .cp0_wdata    (cp0_wdata),
    .mmu_rdata    (mmu_rdata),
    .shadow       (shadow),
    .shadow_valid (shadow_valid)
`ifdef CP0_MMU_SYNC_DIRTY_EN
    ,
    .cp0_wr_strobe (core_we),
    .cp0_wr_rd     (core_rd)
`endif
  );

  // CP0 register file stub: 1-cycle read latency, engine writes and core MTC0 writes.
  always @(posedge clk) begin
    if (cp0_re)  cp0_rdata <= cp0_mem[cp0_rd];
    if (cp0_we)  cp0_mem[cp0_rd] <= cp0_wdata;
    if (core_we) cp0_mem[core_rd] <= core_wd;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack_model();
    logic [255:0] p;
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = sh_model[k];
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) sh_model[k] = '0;
    sv_model    = 1'b0;
    dirty_model = 8'hFF;
  endtask

  // Slots a push will visit, ascending.
  task automatic plan_push();
    vq.delete();
    for (int k = 0; k < 8; k++) begin
`ifdef CP0_MMU_SYNC_DIRTY_EN
      if (!sv_model || dirty_model[k]) vq.push_back(k);
`else
      vq.push_back(k);
`endif
    end
  endtask

  task automatic mtc0(input int rd, input logic [31:0] val);
    @(negedge clk);
    core_we = 1'b1;
    core_rd = 5'(rd);
    core_wd = val;
    @(negedge clk);
    core_we = 1'b0;
    cp0_model[rd] = val;
    for (int k = 0; k < 8; k++) if (map_ref[k] == rd) dirty_model[k] = 1'b1;
  endtask

  // d: direction, m: pull mask, f: flush cycle (0 = none), bs: cycle of a stray start (0 = none)
  task automatic run_op(input logic d, input logic [7:0] m, input int f, input int bs);
    int obs_rd[$];
    int obs_wr_rd[$];
    logic [31:0] obs_wr_d[$];
    int exp_wr_rd[$];
    logic [31:0] exp_wr_d[$];
    int done_cyc = -1, cyc = 0, exp_done, exp_nrd, nvis;
    logic both = 1'b0;
    plan_push();
    nvis = vq.size();
    @(negedge clk);
    start = 1'b1; dir = d; pull_mask = m;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cp0_re) obs_rd.push_back(int'(cp0_rd));
      if (cp0_we) begin
        obs_wr_rd.push_back(int'(cp0_rd));
        obs_wr_d.push_back(cp0_wdata);
      end
      if (cp0_re && cp0_we) both = 1'b1;
      if (done) done_cyc = cyc;
      if (f > 0 && cyc == f + 1) check("flush_idle", busy, 1'b0);
      start = (cyc == bs) || (cyc == f);
      dir   = (cyc == bs) ? ~d : d;
      flush = (cyc == f);
      if (done_cyc >= 0) break;
      if (f > 0 && cyc >= f + 4) break;
    end
    start = 1'b0; flush = 1'b0;
    if (d == 1'b0) begin
      if (f == 0) begin
        exp_done = (nvis == 0) ? 1 : nvis + 2;
        exp_nrd  = nvis;
        foreach (vq[j]) begin
          sh_model[vq[j]] = cp0_model[map_ref[vq[j]]];
          dirty_model[vq[j]] = 1'b0;
        end
        sv_model = 1'b1;
      end else begin
        exp_done = -1;
        exp_nrd  = (f < nvis) ? f : nvis;
        for (int j = 0; j < nvis; j++)
          if (j + 2 < f) sh_model[vq[j]] = cp0_model[map_ref[vq[j]]];
        sv_model    = 1'b0;
        dirty_model = 8'hFF;
      end
    end else begin
      exp_done = 9;
      exp_nrd  = 0;
      for (int k = 0; k < 8; k++) begin
        if (m[k]) begin
          exp_wr_rd.push_back(map_ref[k]);
          exp_wr_d.push_back(mmu_rdata[k*32 +: 32]);
          sh_model[k] = mmu_rdata[k*32 +: 32];
          cp0_model[map_ref[k]] = mmu_rdata[k*32 +: 32];
          dirty_model[k] = 1'b0;
        end
      end
    end
    check("done_cycle", done_cyc, exp_done);
    check("read_count", obs_rd.size(), exp_nrd);
    for (int j = 0; j < obs_rd.size() && j < exp_nrd; j++) check("read_rd", obs_rd[j], map_ref[vq[j]]);
    check("write_count", obs_wr_rd.size(), exp_wr_rd.size());
    for (int j = 0; j < obs_wr_rd.size() && j < exp_wr_rd.size(); j++) begin
      check("write_rd", obs_wr_rd[j], exp_wr_rd[j]);
      check("write_data", obs_wr_d[j], exp_wr_d[j]);
    end
    check("re_we_overlap", both, 1'b0);
    check("shadow", shadow, pack_model());
    check("shadow_valid", shadow_valid, sv_model);
    $display("[TB] op %0d %s mask=%02h flush@%0d stray@%0d done@%0d reads=%0d writes=%0d",
             op_num, d ? "pull" : "push", m, f, bs, done_cyc, obs_rd.size(), obs_wr_rd.size());
    op_num++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, r;
    logic [31:0] v;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_re_we", {cp0_re, cp0_we}, 2'b00);
    check("rst_rd", cp0_rd, 5'd0);
    check("rst_wdata", cp0_wdata, 32'd0);
    check("rst_shadow", shadow, 256'd0);
    check("rst_valid", shadow_valid, 1'b0);
    res_n = 1'b1;

    for (int rr = 0; rr < 32; rr++) begin
      v = $urandom;
      for (int k = 0; k < 8; k++) if (map_ref[k] == rr) v = 32'h100 + 32'(k);
      mtc0(rr, v);
    end

    // Asynchronous reset in the middle of a push.
    @(negedge clk); start = 1'b1; dir = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); res_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_re", cp0_re, 1'b0);
    check("midrst_rd", cp0_rd, 5'd0);
    check("midrst_shadow", shadow, 256'd0);
    check("midrst_valid", shadow_valid, 1'b0);
    model_reset();
    @(negedge clk); res_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", busy, 1'b0);

    run_op(1'b0, 8'h00, 0, 0);
    for (int k = 0; k < 8; k++) mmu_rdata[k*32 +: 32] = 32'hA0 + 32'(k);
    run_op(1'b1, 8'b1000_0101, 0, 0);

    // Stray start while busy, then back-to-back start right after done.
    run_op(1'b0, 8'h00, 0, 3);
    run_op(1'b1, 8'h3C, 0, 4);

    // flush at cycle 4 of a push, with fresh CP0 contents.
    for (int k = 0; k < 8; k++) mtc0(map_ref[k], $urandom);
    run_op(1'b0, 8'h00, 4, 0);

    // flush and start together in IDLE.
    @(negedge clk); start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    dirty_model = 8'hFF;
    check("idle_flush_start", busy, 1'b0);

    run_op(1'b0, 8'h00, 0, 0);
    mtc0(5, 32'hDEAD_0005);
    run_op(1'b0, 8'h00, 0, 0);
    run_op(1'b0, 8'h00, 0, 0);

    for (int it = 0; it < 24; it++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: mtc0(map_ref[$urandom_range(0, 7)], $urandom);
        1: begin
          plan_push();
          f = 0;
          if (vq.size() > 0 && $urandom_range(0, 1) == 1) f = $urandom_range(1, vq.size() + 1);
          run_op(1'b0, 8'h00, f, 0);
        end
        2: begin
          for (int k = 0; k < 8; k++) mmu_rdata[k*32 +: 32] = $urandom;
          run_op(1'b1, 8'($urandom), 0, 0);
        end
        default: run_op(1'b0, 8'h00, 0, 0);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
